// File: rtl/alu_result_skid.sv
// Two-entry skid buffer between the ALU and writeback: registers result, remainder, zero flag and rd.
// in_ready comes from state flops only, which keeps the writeback ready path out of execute timing.
//
//   state | meaning
//   EMPTY | no entry held, out_valid=0, in_ready=1
//   ONE   | main holds the head entry, skid unused
//   FULL  | main holds the head, skid holds the next entry, in_ready=0
module alu_result_skid #(
    parameter int WIDTH   = 16,
    parameter int RD_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_result,
    input  logic [WIDTH-1:0]   in_remainder,
    input  logic               in_zero,
    input  logic [RD_BITS-1:0] in_rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [WIDTH-1:0]   out_remainder,
    output logic               out_zero,
    output logic [RD_BITS-1:0] out_rd,
    output logic [7:0]         overflow_cnt
);

    localparam int PW = 2 * WIDTH + 1 + RD_BITS;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   in_pay;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            accept;
    logic            issue;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    assign in_pay    = {in_result, in_remainder, in_zero, in_rd};
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign accept    = in_valid & in_ready;
    assign issue     = out_valid & out_ready;

    assign {out_result, out_remainder, out_zero, out_rd} = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // flush wins over accept and issue: no loads happen on a flush cycle
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_main_in = 1'b1;
                        state_nxt    = ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (issue) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        load_main_skid = 1'b1;
                        state_nxt      = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_pay;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_pay;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= 8'h00;
        end else if (in_valid && !in_ready && (overflow_cnt != 8'hFF)) begin
            overflow_cnt <= overflow_cnt + 8'h01;
        end
    end

endmodule
